// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
// Module : mem_wb_stage_pkg
// Brief  : Shared widths, opcodes and FSM encodings for the MEM/WB stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

    localparam int DSIZE = 32;
    localparam int ASIZE = 5;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_MUL  = 4'h1,
        OP_ADDI = 4'h2,
        OP_LW   = 4'h3,
        OP_SW   = 4'h4,
        OP_BNE  = 4'h5
    } opcode_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_e;

endpackage : mem_wb_stage_pkg

`default_nettype wire

// File: rtl/mem_wb_stage_mem_req_ctrl.sv
// ============================================================================
// Module : mem_req_ctrl
// Brief  : Data-memory request holder with ack/timeout tracking and sticky err.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_req_ctrl #(
    parameter int DSIZE   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_we,
    input  logic [DSIZE-1:0] i_addr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic             i_ack,
    output logic             o_req,
    output logic             o_we,
    output logic [DSIZE-1:0] o_addr,
    output logic [DSIZE-1:0] o_wdata,
    output logic             o_done,
    output logic             o_timeout,
    output logic             o_err
);

    localparam int              CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

    logic             r_req;
    logic             r_we;
    logic [DSIZE-1:0] r_addr;
    logic [DSIZE-1:0] r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_done;
    logic             w_timeout;

    // Ack takes priority over an expiring counter on the same edge.
    assign w_done    = r_req & i_ack;
    assign w_timeout = r_req & ~i_ack & (r_cnt == C_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else if (r_req) begin
            if (w_done) begin
                r_req <= 1'b0;
            end else if (w_timeout) begin
                r_req <= 1'b0;
                r_err <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_start) begin
            r_req   <= 1'b1;
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_cnt   <= '0;
        end
    end

    assign o_req     = r_req;
    assign o_we      = r_we;
    assign o_addr    = r_addr;
    assign o_wdata   = r_wdata;
    assign o_done    = w_done;
    assign o_timeout = w_timeout;
    assign o_err     = r_err;

endmodule : mem_req_ctrl

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module : mem_wb_stage
// Brief  : Memory access, BNE resolution and register writeback after the ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
    parameter int DSIZE   = mem_wb_stage_pkg::DSIZE,
    parameter int ASIZE   = mem_wb_stage_pkg::ASIZE,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       instr_code,
    input  logic [DSIZE-1:0] alu_out,
    input  logic             zero,
    input  logic [DSIZE-1:0] store_data,
    input  logic [ASIZE-1:0] rd,
    input  logic [DSIZE-1:0] pc,
    input  logic [DSIZE-1:0] imm,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DSIZE-1:0] dmem_addr,
    output logic [DSIZE-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [DSIZE-1:0] dmem_rdata,
    output logic             wb_en,
    output logic [ASIZE-1:0] wb_addr,
    output logic [DSIZE-1:0] wb_data,
    output logic             br_taken,
    output logic [DSIZE-1:0] br_target,
    output logic             err
);

    import mem_wb_stage_pkg::*;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mem_wb_stage: TIMEOUT must be >= 2");
    end

    state_e           r_state;
    logic [ASIZE-1:0] r_rd;
    logic             r_is_lw;
    logic             r_wb_en;
    logic [ASIZE-1:0] r_wb_addr;
    logic [DSIZE-1:0] r_wb_data;
    logic             r_br_taken;
    logic [DSIZE-1:0] r_br_target;

    logic             w_accept;
    logic             w_is_lw;
    logic             w_is_sw;
    logic             w_start;
    logic             w_done;
    logic             w_timeout;

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_ready & in_valid;
    assign w_is_lw  = (instr_code == OP_LW);
    assign w_is_sw  = (instr_code == OP_SW);
    assign w_start  = w_accept & (w_is_lw | w_is_sw);

    mem_req_ctrl #(
        .DSIZE   (DSIZE),
        .TIMEOUT (TIMEOUT)
    ) u_mem_req_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_we      (w_is_sw),
        .i_addr    (alu_out),
        .i_wdata   (w_is_sw ? store_data : '0),
        .i_ack     (dmem_ack),
        .o_req     (dmem_req),
        .o_we      (dmem_we),
        .o_addr    (dmem_addr),
        .o_wdata   (dmem_wdata),
        .o_done    (w_done),
        .o_timeout (w_timeout),
        .o_err     (err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rd        <= '0;
            r_is_lw     <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_wb_en    <= 1'b0;
            r_br_taken <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        case (instr_code)
                            OP_ADD, OP_MUL, OP_ADDI: begin
                                // x0 is hardwired; suppress the strobe entirely.
                                if (rd != '0) begin
                                    r_wb_en   <= 1'b1;
                                    r_wb_addr <= rd;
                                    r_wb_data <= alu_out;
                                end
                            end
                            OP_BNE: begin
                                if (!zero) begin
                                    r_br_taken  <= 1'b1;
                                    r_br_target <= pc + imm;
                                end
                            end
                            OP_LW, OP_SW: begin
                                r_state <= MEM;
                                r_rd    <= rd;
                                r_is_lw <= w_is_lw;
                            end
                            default: ;
                        endcase
                    end
                end
                MEM: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        if (r_is_lw && (r_rd != '0)) begin
                            r_wb_en   <= 1'b1;
                            r_wb_addr <= r_rd;
                            r_wb_data <= dmem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;

endmodule : mem_wb_stage

`default_nettype wire
